// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  // ID-stage instruction
  input  logic          IF_ID_Valid,
  input  logic [4:0]    IF_ID_RS,
  input  logic [4:0]    IF_ID_RT,
  input  logic [4:0]    IF_ID_RD,
  input  logic          IF_ID_UsesRT,
  input  logic          IF_ID_RegWrite,
  input  logic          IF_ID_MemRead,
  input  logic          IF_ID_MemWrite,
  input  logic          IF_ID_MemtoReg,
  input  logic          IF_ID_ALUSrc,
  input  logic [3:0]    IF_ID_ALUCtrl,
  input  logic [DW-1:0] IF_ID_RS_data,
  input  logic [DW-1:0] IF_ID_RT_data,
  input  logic [DW-1:0] IF_ID_Imm,
  input  logic [DW-1:0] IF_ID_PC,
  // pipeline control
  input  logic          Flush,
  input  logic          Hold,
  input  logic          CntClr,
  // registered stage contents
  output logic          ID_EX_Valid,
  output logic [4:0]    ID_EX_RS,
  output logic [4:0]    ID_EX_RT,
  output logic [4:0]    ID_EX_RD,
  output logic          ID_EX_UsesRT,
  output logic          ID_EX_RegWrite,
  output logic          ID_EX_MemRead,
  output logic          ID_EX_MemWrite,
  output logic          ID_EX_MemtoReg,
  output logic          ID_EX_ALUSrc,
  output logic [3:0]    ID_EX_ALUCtrl,
  output logic [DW-1:0] ID_EX_RS_data,
  output logic [DW-1:0] ID_EX_RT_data,
  output logic [DW-1:0] ID_EX_Imm,
  output logic [DW-1:0] ID_EX_PC,
  // hazard outputs
  output logic          PCWrite,
  output logic          IF_ID_Write,
  output logic          Stall,
  output logic [CW-1:0] StallCnt,
  output logic [CW-1:0] FlushCnt
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          uses_rt;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } stage_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  stage_t        stage_q, stage_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic          hz;
  logic          stall;
  logic          src_match;

  // Load in EX whose destination feeds the instruction now in ID.
  assign src_match = (stage_q.rd == IF_ID_RS) | (IF_ID_UsesRT & (stage_q.rd == IF_ID_RT));
  assign hz        = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & IF_ID_Valid & src_match;
  // A flush kills the dependent instruction, and a hold freezes everything,
  // so either one suppresses the stall.
  assign stall     = hz & ~Flush & ~Hold;

  assign Stall       = stall;
  assign PCWrite     = ~(stall | Hold);
  assign IF_ID_Write = ~(stall | Hold);

  // Next stage contents: hold > flush/stall bubble > load from ID.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    stage_d = stage_q;
    if (Hold) begin
      stage_d = stage_q;
    end else if (Flush || stall) begin
      // Bubble: kill validity and every state-changing control bit; the
      // remaining fields keep their old values since nothing consumes them.
      stage_d.valid      = 1'b0;
      stage_d.reg_write  = 1'b0;
      stage_d.mem_read   = 1'b0;
      stage_d.mem_write  = 1'b0;
      stage_d.mem_to_reg = 1'b0;
    end else begin
      stage_d.valid      = IF_ID_Valid;
      stage_d.rs         = IF_ID_RS;
      stage_d.rt         = IF_ID_RT;
      stage_d.rd         = IF_ID_RD;
      stage_d.uses_rt    = IF_ID_UsesRT;
      stage_d.rs_data    = IF_ID_RS_data;
      stage_d.rt_data    = IF_ID_RT_data;
      stage_d.imm        = IF_ID_Imm;
      stage_d.pc         = IF_ID_PC;
      // Invalid slots carry no control so they can never write anything.
      stage_d.reg_write  = IF_ID_Valid & IF_ID_RegWrite;
      stage_d.mem_read   = IF_ID_Valid & IF_ID_MemRead;
      stage_d.mem_write  = IF_ID_Valid & IF_ID_MemWrite;
      stage_d.mem_to_reg = IF_ID_Valid & IF_ID_MemtoReg;
      stage_d.alu_src    = IF_ID_Valid & IF_ID_ALUSrc;
      stage_d.alu_ctrl   = IF_ID_Valid ? IF_ID_ALUCtrl : 4'd0;
    end
  end

  // Saturating event counters; clear wins over increment, hold freezes both.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!Hold) begin
      if (CntClr) begin
        stall_cnt_d = '0;
        flush_cnt_d = '0;
      end else begin
        if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (Flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset empties the stage and zeroes the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    if (!rst_n) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_EX_Valid    = stage_q.valid;
  assign ID_EX_RS       = stage_q.rs;
  assign ID_EX_RT       = stage_q.rt;
  assign ID_EX_RD       = stage_q.rd;
  assign ID_EX_UsesRT   = stage_q.uses_rt;
  assign ID_EX_RegWrite = stage_q.reg_write;
  assign ID_EX_MemRead  = stage_q.mem_read;
  assign ID_EX_MemWrite = stage_q.mem_write;
  assign ID_EX_MemtoReg = stage_q.mem_to_reg;
  assign ID_EX_ALUSrc   = stage_q.alu_src;
  assign ID_EX_ALUCtrl  = stage_q.alu_ctrl;
  assign ID_EX_RS_data  = stage_q.rs_data;
  assign ID_EX_RT_data  = stage_q.rt_data;
  assign ID_EX_Imm      = stage_q.imm;
  assign ID_EX_PC       = stage_q.pc;
  assign StallCnt       = stall_cnt_q;
  assign FlushCnt       = flush_cnt_q;

endmodule
